// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage: register file with write-through, operand forwarding,
// immediate/target generation and a registered ID/EX boundary. Optional load-use
// interlock is enabled by defining HAZARD_DETECT_EN.
module decode_stage_pipe #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 8,
  parameter int LINK_REG   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [15:0]           instruction,
  input  logic [DATA_W-1:0]     npc,
  input  logic                  src1_zero,
  input  logic                  src2_rt,
  input  logic                  rd_link,
  input  logic                  ext_op,
  input  logic                  ext_place,
  input  logic [1:0]            fwd_a,
  input  logic [1:0]            fwd_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic [DATA_W-1:0]     wb_result,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard_stall,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     a,
  output logic [DATA_W-1:0]     b,
  output logic [DATA_W-1:0]     imm,
  output logic [DATA_W-1:0]     i_target,
  output logic [DATA_W-1:0]     j_target,
  output logic [DATA_W-1:0]     return_addr,
  output logic [DATA_W-1:0]     pc_out,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  gt,
  output logic                  lt,
  output logic                  eq
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] LINK_IDX = REG_ADDR_W'(LINK_REG);

  logic [DATA_W-1:0]     rf_reg [NUM_REGS];
  logic [REG_ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0]     rd_data [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      rf_reg[wb_rd] <= wb_result;
    end
  end

  // Read ports: 0 = RA, 1 = RB, 2 = link register
  assign rd_addr[0] = src1_zero ? '0 : REG_ADDR_W'(instruction[8:6]);
  assign rd_addr[1] = src2_rt ? REG_ADDR_W'(instruction[5:3]) : REG_ADDR_W'(instruction[11:9]);
  assign rd_addr[2] = LINK_IDX;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_read
      assign rd_data[gi] = (rd_addr[gi] == '0)                 ? '0 :
                           (wb_en && (wb_rd == rd_addr[gi]))   ? wb_result :
                                                                 rf_reg[rd_addr[gi]];
    end
  endgenerate

  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_val,
    input logic [DATA_W-1:0] alu_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    case (sel)
      2'd1:    return alu_val;
      2'd2:    return mem_val;
      2'd3:    return wb_val;
      default: return rf_val;
    endcase
  endfunction

  logic [DATA_W-1:0]     a_next, b_next, imm_next, i_target_next, j_target_next;
  logic [REG_ADDR_W-1:0] dest_next;
  logic [IMM_W-1:0]      imm_field;
  logic                  hazard;

  assign a_next    = fwd_mux(fwd_a, rd_data[0], alu_result, mem_result, wb_result);
  assign b_next    = fwd_mux(fwd_b, rd_data[1], alu_result, mem_result, wb_result);
  assign imm_field = instruction[IMM_W-1:0];

  always_comb begin
    imm_next = {{(DATA_W-IMM_W){1'b0}}, imm_field};
    if (ext_place)
      imm_next = {imm_field, {(DATA_W-IMM_W){1'b0}}};
    else if (ext_op)
      imm_next = {{(DATA_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};
  end

  assign i_target_next = npc + imm_next;
  assign j_target_next = {npc[DATA_W-1:12], instruction[11:0]};
  assign dest_next     = rd_link ? LINK_IDX : REG_ADDR_W'(instruction[11:9]);

  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[15:12];

`ifdef HAZARD_DETECT_EN
  assign hazard = in_valid && ex_is_load && (ex_rd != '0) &&
                  ((ex_rd == rd_addr[0]) || (ex_rd == rd_addr[1]));
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{ex_is_load, ex_rd};
  assign hazard = 1'b0;
`endif

  assign hazard_stall = hazard;

  logic                  valid_reg;
  logic [DATA_W-1:0]     a_reg, b_reg, imm_reg, i_target_reg, j_target_reg, ret_reg, pc_reg;
  logic [REG_ADDR_W-1:0] rd_reg;

  // A flushed or bubbled slot only clears valid and rd; data simply holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      imm_reg      <= '0;
      i_target_reg <= '0;
      j_target_reg <= '0;
      ret_reg      <= '0;
      pc_reg       <= '0;
      rd_reg       <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      rd_reg    <= '0;
    end else if (stall) begin
      valid_reg <= valid_reg;
    end else if (hazard) begin
      valid_reg <= 1'b0;
      rd_reg    <= '0;
    end else begin
      valid_reg    <= in_valid;
      a_reg        <= a_next;
      b_reg        <= b_next;
      imm_reg      <= imm_next;
      i_target_reg <= i_target_next;
      j_target_reg <= j_target_next;
      ret_reg      <= rd_data[2];
      pc_reg       <= npc;
      rd_reg       <= dest_next;
    end
  end

  assign out_valid   = valid_reg;
  assign a           = a_reg;
  assign b           = b_reg;
  assign imm         = imm_reg;
  assign i_target    = i_target_reg;
  assign j_target    = j_target_reg;
  assign return_addr = ret_reg;
  assign pc_out      = pc_reg;
  assign rd          = rd_reg;

  assign gt = $signed(a_reg) >  $signed(b_reg);
  assign lt = $signed(a_reg) <  $signed(b_reg);
  assign eq = (a_reg == b_reg);

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: stimulus queues hand-computed expectations,
// a monitor compares them one clock edge later.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush;
  logic [15:0] instruction, npc;
  logic        src1_zero, src2_rt, rd_link, ext_op, ext_place;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] alu_result, mem_result, wb_result;
  logic        wb_en;
  logic [2:0]  wb_rd, ex_rd;
  logic        ex_is_load;
  logic        hazard_stall, out_valid, gt, lt, eq;
  logic [15:0] a, b, imm, i_target, j_target, return_addr, pc_out;
  logic [2:0]  rd;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .instruction(instruction), .npc(npc), .src1_zero(src1_zero), .src2_rt(src2_rt),
    .rd_link(rd_link), .ext_op(ext_op), .ext_place(ext_place), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .alu_result(alu_result), .mem_result(mem_result), .wb_result(wb_result),
    .wb_en(wb_en), .wb_rd(wb_rd), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .hazard_stall(hazard_stall), .out_valid(out_valid), .a(a), .b(b), .imm(imm),
    .i_target(i_target), .j_target(j_target), .return_addr(return_addr),
    .pc_out(pc_out), .rd(rd), .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  localparam int M_V = 1, M_A = 2, M_B = 4, M_IMM = 8, M_IT = 16, M_JT = 32;
  localparam int M_RA = 64, M_PC = 128, M_RD = 256, M_F = 512, M_HZ = 1024;
  localparam int M_ALL = 2047;

  typedef struct {
    string       name;
    int          mask;
    logic        v;
    logic [15:0] a, b, imm, it, jt, ra, pc;
    logic [2:0]  rd, f;
    logic        hz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic exp_push(input string n, input int m, input logic v,
                          input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] eimm,
                          input logic [15:0] eit, input logic [15:0] ejt, input logic [15:0] era,
                          input logic [15:0] epc, input logic [2:0] erd, input logic [2:0] ef,
                          input logic ehz);
    exp_t e;
    e.name = n; e.mask = m; e.v = v; e.a = ea; e.b = eb; e.imm = eimm; e.it = eit;
    e.jt = ejt; e.ra = era; e.pc = epc; e.rd = erd; e.f = ef; e.hz = ehz;
    sb.push_back(e);
  endtask

  task automatic cmp(input string n, input string fld, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %h, expected %h", n, fld, act, req);
    end
  endtask

  task automatic check_entry(input exp_t e);
    if ((e.mask & M_V)   != 0) cmp(e.name, "valid", 16'(out_valid), 16'(e.v));
    if ((e.mask & M_A)   != 0) cmp(e.name, "a", a, e.a);
    if ((e.mask & M_B)   != 0) cmp(e.name, "b", b, e.b);
    if ((e.mask & M_IMM) != 0) cmp(e.name, "imm", imm, e.imm);
    if ((e.mask & M_IT)  != 0) cmp(e.name, "i_target", i_target, e.it);
    if ((e.mask & M_JT)  != 0) cmp(e.name, "j_target", j_target, e.jt);
    if ((e.mask & M_RA)  != 0) cmp(e.name, "return_addr", return_addr, e.ra);
    if ((e.mask & M_PC)  != 0) cmp(e.name, "pc_out", pc_out, e.pc);
    if ((e.mask & M_RD)  != 0) cmp(e.name, "rd", 16'(rd), 16'(e.rd));
    if ((e.mask & M_F)   != 0) cmp(e.name, "gt_lt_eq", 16'({gt, lt, eq}), 16'(e.f));
    if ((e.mask & M_HZ)  != 0) cmp(e.name, "hazard_stall", 16'(hazard_stall), 16'(e.hz));
    $display("vec %-12s valid=%b a=%h b=%h imm=%h it=%h jt=%h ra=%h pc=%h rd=%0d f=%b hz=%b",
             e.name, out_valid, a, b, imm, i_target, j_target, return_addr, pc_out, rd,
             {gt, lt, eq}, hazard_stall);
  endtask

  // Monitor: every expectation queued before an edge is checked just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_entry(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic dflt();
    in_valid = 1'b1; stall = 1'b0; flush = 1'b0; instruction = 16'h0; npc = 16'h0;
    src1_zero = 1'b0; src2_rt = 1'b0; rd_link = 1'b0; ext_op = 1'b0; ext_place = 1'b0;
    fwd_a = 2'd0; fwd_b = 2'd0; alu_result = 16'h0; mem_result = 16'h0; wb_result = 16'h0;
    wb_en = 1'b0; wb_rd = 3'd0; ex_is_load = 1'b0; ex_rd = 3'd0;
  endtask

  task automatic nxt();
    @(negedge clk);
    dflt();
  endtask

  initial begin
    rst_n = 1'b0;
    dflt();

    // reset state
    nxt();
    exp_push("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0);

    // write R3 while reading it, then read the stored value
    nxt(); rst_n = 1'b1;
    wb_en = 1; wb_rd = 3; wb_result = 16'h5555; instruction = 16'h00C0; npc = 16'h0010;
    exp_push("wt_pre", M_ALL, 1, 16'h5555, 0, 16'h00C0, 16'h00D0, 16'h00C0, 0, 16'h0010, 0, 3'b100, 0);
    nxt(); instruction = 16'h00C0; npc = 16'h0010;
    exp_push("rf_hold", M_V | M_A, 1, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset asserted mid-cycle with a write pending
    nxt(); wb_en = 1; wb_rd = 5; wb_result = 16'h1234;
    exp_push("reset_mid", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0);
    #2 rst_n = 1'b0;
    nxt(); rst_n = 1'b1; instruction = 16'h0AC0; npc = 16'h0000;
    exp_push("post_reset", M_ALL, 1, 0, 0, 16'h00C0, 16'h00C0, 16'h0AC0, 0, 0, 3'd5, 3'b001, 0);

    // write-through on RA, RB and link reads
    nxt(); wb_en = 1; wb_rd = 3; wb_result = 16'h0008; instruction = 16'h00C0; npc = 16'h0020;
    exp_push("wt_a", M_ALL, 1, 16'h0008, 0, 16'h00C0, 16'h00E0, 16'h00C0, 0, 16'h0020, 0, 3'b100, 0);
    nxt(); wb_en = 1; wb_rd = 7; wb_result = 16'hBEEF; instruction = 16'h0018; npc = 16'h0100;
    rd_link = 1; src2_rt = 1;
    exp_push("wt_link", M_ALL, 1, 0, 16'h0008, 16'h0018, 16'h0118, 16'h0018, 16'hBEEF, 16'h0100, 3'd7, 3'b010, 0);
    nxt(); instruction = 16'h00C0; src1_zero = 1;
    exp_push("src1_zero", M_V | M_A | M_B | M_RA | M_F, 1, 0, 0, 0, 0, 0, 16'hBEEF, 0, 0, 3'b001, 0);

    // immediate extension and targets
    nxt(); instruction = 16'h00F0; ext_op = 1; npc = 16'h0002;
    exp_push("sext", M_V | M_IMM | M_IT | M_JT, 1, 0, 0, 16'hFFF0, 16'hFFF2, 16'h00F0, 0, 0, 0, 0, 0);
    nxt(); instruction = 16'h00F0; ext_op = 1; ext_place = 1; npc = 16'h0002;
    exp_push("place_hi", M_IMM | M_IT, 1, 0, 0, 16'hF000, 16'hF002, 0, 0, 0, 0, 0, 0);
    nxt(); instruction = 16'h00F0; npc = 16'h0002;
    exp_push("zext", M_IMM | M_IT, 1, 0, 0, 16'h00F0, 16'h00F2, 0, 0, 0, 0, 0, 0);
    nxt(); instruction = 16'h0ABC; npc = 16'hA123;
    exp_push("jtgt", M_IMM | M_IT | M_JT | M_PC | M_RD, 1, 0, 0, 16'h00BC, 16'hA1DF, 16'hAABC, 0, 16'hA123, 3'd5, 0, 0);
    nxt(); instruction = 16'h0002; npc = 16'hFFFF;
    exp_push("itgt_wrap", M_IT | M_JT, 1, 0, 0, 0, 16'h0001, 16'hF002, 0, 0, 0, 0, 0);

    // forwarding and signed compare
    nxt(); fwd_a = 1; alu_result = 16'h000A; fwd_b = 2; mem_result = 16'h000C;
    exp_push("fwd_lt", M_V | M_A | M_B | M_F, 1, 16'h000A, 16'h000C, 0, 0, 0, 0, 0, 0, 3'b010, 0);
    nxt(); fwd_a = 3; wb_result = 16'hFFFF; fwd_b = 1; alu_result = 16'h0001;
    exp_push("signed_lt", M_A | M_B | M_F, 1, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0, 3'b010, 0);
    nxt(); fwd_a = 1; alu_result = 16'h0001; fwd_b = 3; wb_result = 16'hFFFF;
    exp_push("signed_gt", M_A | M_B | M_F, 1, 16'h0001, 16'hFFFF, 0, 0, 0, 0, 0, 0, 3'b100, 0);
    nxt(); fwd_a = 2; fwd_b = 2; mem_result = 16'h8000;
    exp_push("fwd_eq", M_A | M_B | M_F, 1, 16'h8000, 16'h8000, 0, 0, 0, 0, 0, 0, 3'b001, 0);

    // stall / flush control
    nxt(); fwd_a = 1; fwd_b = 1; alu_result = 16'h1111; instruction = 16'h0E05; npc = 16'h0040;
    exp_push("load_v", M_ALL, 1, 16'h1111, 16'h1111, 16'h0005, 16'h0045, 16'h0E05, 16'hBEEF, 16'h0040, 3'd7, 3'b001, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); stall = 1; in_valid = 0; fwd_a = 1; alu_result = 16'h2222 + 16'(i); npc = 16'h0099;
      exp_push("stall", M_ALL, 1, 16'h1111, 16'h1111, 16'h0005, 16'h0045, 16'h0E05, 16'hBEEF, 16'h0040, 3'd7, 3'b001, 0);
    end
    nxt(); stall = 1; flush = 1;
    exp_push("flush_stall", M_V | M_RD | M_A, 0, 16'h1111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); in_valid = 0; fwd_a = 1; alu_result = 16'h2222;
    exp_push("invalid_load", M_V | M_A, 0, 16'h2222, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); flush = 1; instruction = 16'h0E05;
    exp_push("flush", M_V | M_RD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); instruction = 16'h0E05; fwd_a = 1; alu_result = 16'h3333;
    exp_push("resume", M_V | M_A | M_RD, 1, 16'h3333, 0, 0, 0, 0, 0, 0, 3'd7, 0, 0);

    // load-use interlock
    nxt(); ex_is_load = 1; ex_rd = 4; instruction = 16'h0100; fwd_a = 1; alu_result = 16'h4444;
`ifdef HAZARD_DETECT_EN
    exp_push("hz_bubble", M_V | M_RD | M_A | M_HZ, 0, 16'h3333, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nxt(); instruction = 16'h0100; fwd_a = 1; alu_result = 16'h4444;
    exp_push("hz_issue", M_V | M_A | M_HZ, 1, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); ex_is_load = 1; ex_rd = 4; instruction = 16'h0800; fwd_a = 1; alu_result = 16'h5555;
    exp_push("hz_rb", M_V | M_A | M_HZ, 0, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
    exp_push("hz_off", M_V | M_A | M_HZ, 1, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    nxt(); in_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
